fpga_buffer_streamer: RTL and testbench

FPGA_BUFFER_STREAMER -- requirements
Module: fpga_buffer_streamer

---
 rtl/fpga_buffer_streamer.sv | 173 +++++++++++++++++
 tb/tb_fpga_buffer_streamer.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpga_buffer_streamer.sv
// Register-mapped RAM buffer with single-word read/write commands and an
// AXI4-Stream dump engine (fetch/send, one beat per two cycles at best).
module fpga_buffer_streamer #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        avs_address,
  input  logic              avs_chipselect,
  input  logic              avs_write_n,
  input  logic [31:0]       avs_writedata,
  output logic [31:0]       avs_readdata,
  output logic [DATA_W-1:0] axis4_m_tdata,
  output logic              axis4_m_tvalid,
  output logic              axis4_m_tlast,
  input  logic              axis4_m_tready
);
  localparam int LEN_W = ADDR_W + 1;
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE, S_WRITE, S_READ_WAIT, S_DUMP_FETCH, S_DUMP_SEND
  } state_t;

  state_t r_state, w_next;

  logic [1:0]        r_ctrl_cmd;
  logic [ADDR_W-1:0] r_ctrl_addr, r_ptr;
  logic [DATA_W-1:0] r_data_wr, r_data_rd, r_op, r_rdata;
  logic [LEN_W-1:0]  r_dump, r_len, r_cnt;
  logic              r_err, r_done, r_aborted, r_abort_pend, r_rphase;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic       w_wr, w_go, w_abort, w_stat_clr, w_busy, w_cmd_ok, w_start;
  logic       w_hs, w_last, w_end, w_send, w_rd_en, w_unused;
  logic [1:0] w_cmd;

  assign w_wr       = avs_chipselect && !avs_write_n;
  assign w_cmd      = avs_writedata[2:1];
  assign w_go       = w_wr && (avs_address == 2'd0) && avs_writedata[0];
  assign w_abort    = w_wr && (avs_address == 2'd0) && avs_writedata[3];
  assign w_stat_clr = w_wr && (avs_address == 2'd1) && avs_writedata[0];
  assign w_busy     = (r_state != S_IDLE);
  assign w_cmd_ok   = (w_cmd == 2'b00) || (w_cmd == 2'b01) ||
                      ((w_cmd == 2'b10) && (r_dump != '0));
  assign w_start    = w_go && !w_busy && w_cmd_ok;
  assign w_send     = (r_state == S_DUMP_SEND);
  assign w_hs       = w_send && axis4_m_tready;
  assign w_last     = ((r_cnt + LEN_W'(1)) == r_len);
  // An abort arriving in the same cycle as a handshake still ends the dump there.
  assign w_end      = w_hs && (w_last || r_abort_pend || w_abort);
  assign w_rd_en    = ((r_state == S_READ_WAIT) && !r_rphase) || (r_state == S_DUMP_FETCH);
  assign w_unused   = ^avs_writedata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_start) begin
        case (w_cmd)
          2'b00:   w_next = S_READ_WAIT;
          2'b01:   w_next = S_WRITE;
          default: w_next = S_DUMP_FETCH;
        endcase
      end
      S_WRITE:      w_next = S_IDLE;
      S_READ_WAIT:  if (r_rphase) w_next = S_IDLE;
      S_DUMP_FETCH: w_next = w_abort ? S_IDLE : S_DUMP_SEND;
      S_DUMP_SEND:  if (w_hs) w_next = w_end ? S_IDLE : S_DUMP_FETCH;
      default:      w_next = S_IDLE;
    endcase
  end

  // RAM contents survive reset; r_rdata is only visible through gated outputs.
  always_ff @(posedge clk) begin
    if (r_state == S_WRITE) r_mem[r_ptr] <= r_op;
    if (w_rd_en)            r_rdata      <= r_mem[r_ptr];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ctrl_cmd   <= '0;
      r_ctrl_addr  <= '0;
      r_data_wr    <= '0;
      r_data_rd    <= '0;
      r_op         <= '0;
      r_dump       <= '0;
      r_len        <= '0;
      r_cnt        <= '0;
      r_ptr        <= '0;
      r_err        <= 1'b0;
      r_done       <= 1'b0;
      r_aborted    <= 1'b0;
      r_abort_pend <= 1'b0;
      r_rphase     <= 1'b0;
    end else begin
      if (w_wr && avs_address == 2'd0) begin
        r_ctrl_cmd  <= w_cmd;
        r_ctrl_addr <= avs_writedata[8 +: ADDR_W];
      end
      if (w_wr && avs_address == 2'd2) r_data_wr <= avs_writedata[DATA_W-1:0];
      if (w_wr && avs_address == 2'd3) r_dump    <= avs_writedata[ADDR_W:0];
      if (w_stat_clr) begin
        r_err     <= 1'b0;
        r_done    <= 1'b0;
        r_aborted <= 1'b0;
      end
      if (w_go && !w_start) r_err <= 1'b1;
      if (w_start) begin
        r_ptr        <= avs_writedata[8 +: ADDR_W];
        r_op         <= r_data_wr;
        r_rphase     <= 1'b0;
        r_abort_pend <= 1'b0;
        if (w_cmd == 2'b10) begin
          r_len <= r_dump;
          r_cnt <= '0;
        end
      end
      case (r_state)
        S_WRITE: r_done <= 1'b1;
        S_READ_WAIT: begin
          r_rphase <= ~r_rphase;
          if (r_rphase) begin
            r_data_rd <= r_rdata;
            r_done    <= 1'b1;
          end
        end
        S_DUMP_FETCH: if (w_abort) r_aborted <= 1'b1;
        S_DUMP_SEND: begin
          if (w_abort) r_abort_pend <= 1'b1;
          if (w_hs) begin
            r_cnt <= r_cnt + LEN_W'(1);
            r_ptr <= r_ptr + ADDR_W'(1);
          end
          if (w_end) begin
            r_abort_pend <= 1'b0;
            if (r_abort_pend || w_abort) r_aborted <= 1'b1;
            else                         r_done    <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign axis4_m_tvalid = w_send;
  assign axis4_m_tdata  = w_send ? r_rdata : '0;
  assign axis4_m_tlast  = w_send && (w_last || r_abort_pend);

  always_comb begin
    avs_readdata = '0;
    case (avs_address)
      2'd0: begin
        avs_readdata[2:1]         = r_ctrl_cmd;
        avs_readdata[8 +: ADDR_W] = r_ctrl_addr;
      end
      2'd1: begin
        avs_readdata[0]          = w_busy;
        avs_readdata[1]          = r_err;
        avs_readdata[2]          = r_done;
        avs_readdata[3]          = r_aborted;
        avs_readdata[16 +: LEN_W] = r_cnt;
      end
      2'd2:    avs_readdata[DATA_W-1:0] = r_data_rd;
      default: avs_readdata[LEN_W-1:0]  = r_dump;
    endcase
  end
endmodule

// File: tb/tb_fpga_buffer_streamer.sv
// Bench for fpga_buffer_streamer: register table, directed corner sequences,
// and random commands against an array model of the buffer.
module tb_fpga_buffer_streamer;
  localparam int DW = 8;
  localparam int AW = 5;
  localparam int DEPTH = 32;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [1:0]    avs_address;
  logic          avs_chipselect;
  logic          avs_write_n;
  logic [31:0]   avs_writedata;
  logic [31:0]   avs_readdata;
  logic [DW-1:0] axis4_m_tdata;
  logic          axis4_m_tvalid;
  logic          axis4_m_tlast;
  logic          axis4_m_tready;

  always #5 clk = ~clk;

  fpga_buffer_streamer #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .reset_n(reset_n),
    .avs_address(avs_address), .avs_chipselect(avs_chipselect),
    .avs_write_n(avs_write_n), .avs_writedata(avs_writedata),
    .avs_readdata(avs_readdata),
    .axis4_m_tdata(axis4_m_tdata), .axis4_m_tvalid(axis4_m_tvalid),
    .axis4_m_tlast(axis4_m_tlast), .axis4_m_tready(axis4_m_tready)
  );

  int checks = 0;
  int failures = 0;

  typedef struct { logic [DW-1:0] d; logic l; } beat_t;
  beat_t         q[$];
  logic [DW-1:0] model [DEPTH];
  bit            rdy_rand = 1'b0;
  bit            pv_stall = 1'b0;
  logic [DW-1:0] pv_data;

  typedef struct { string nm; logic [1:0] a; bit wr; logic [31:0] wd; logic [31:0] exp; } vec_t;
  vec_t vt [13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Stream monitor: sampled mid-cycle, so tvalid&&tready here is the handshake
  // at the next rising edge.
  always begin
    @(negedge clk); #2;
    if (!reset_n) pv_stall = 1'b0;
    else begin
      if (pv_stall) begin
        chk("hold_valid", axis4_m_tvalid, 1);
        chk("hold_data", axis4_m_tdata, pv_data);
      end
      if (!axis4_m_tvalid) begin
        chk("idle_data", axis4_m_tdata, 0);
        chk("idle_last", axis4_m_tlast, 0);
      end else if (axis4_m_tready) q.push_back('{axis4_m_tdata, axis4_m_tlast});
      pv_stall = axis4_m_tvalid && !axis4_m_tready;
      pv_data  = axis4_m_tdata;
    end
  end

  always @(negedge clk) if (rdy_rand) axis4_m_tready = 1'($urandom_range(0, 1));

  task automatic avs_wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    avs_address = a; avs_writedata = d; avs_chipselect = 1'b1; avs_write_n = 1'b0;
    @(negedge clk);
    avs_chipselect = 1'b0; avs_write_n = 1'b1;
  endtask

  task automatic avs_rd(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    avs_address = a; #1;
    d = avs_readdata;
  endtask

  // Issue a CTRL write and count the cycles STAT.busy reads 1 afterwards.
  task automatic ctrl_go(input logic [31:0] wd, output int bcyc);
    avs_wr(2'd0, wd);
    avs_address = 2'd1; #1;
    bcyc = 0;
    while (avs_readdata[0] && bcyc < 3000) begin
      bcyc++; @(negedge clk); #1;
    end
    if (bcyc >= 3000) chk("busy_timeout", bcyc, 0);
  endtask

  task automatic wait_idle();
    int n = 0;
    avs_address = 2'd1; #1;
    while (avs_readdata[0] && n < 3000) begin
      n++; @(negedge clk); #1;
    end
    if (n >= 3000) chk("idle_timeout", n, 0);
  endtask

  task automatic wait_valid();
    int n = 0;
    #1;
    while (!axis4_m_tvalid && n < 100) begin
      n++; @(negedge clk); #1;
    end
    if (n >= 100) chk("valid_timeout", n, 0);
  endtask

  task automatic beat_once();
    axis4_m_tready = 1'b1;
    @(negedge clk);
    axis4_m_tready = 1'b0;
  endtask

  task automatic mem_write(input int a, input logic [31:0] d);
    int b;
    avs_wr(2'd2, d);
    ctrl_go(32'h3 | (a << 8), b);
    model[a] = d[DW-1:0];
  endtask

  task automatic mem_read(input int a, output logic [DW-1:0] d);
    int b;
    logic [31:0] r;
    ctrl_go(32'h1 | (a << 8), b);
    avs_rd(2'd2, r);
    d = r[DW-1:0];
  endtask

  // Expected beats come straight from the model: consecutive words from addr,
  // wrapping at DEPTH, tlast on the final requested beat or on the aborted one.
  task automatic chk_dump(input int addr, input int len, input int nacc, input bit ab);
    chk("beat_count", q.size(), nacc);
    for (int i = 0; i < nacc && i < q.size(); i++) begin
      chk("beat_data", q[i].d, model[(addr + i) % DEPTH]);
      chk("beat_last", q[i].l, (i == len - 1) || (ab && i == nacc - 1));
    end
  endtask

  initial begin
    logic [31:0]   r;
    logic [DW-1:0] d;
    int            b, a, len, op;

    vt[0]  = '{"rst_ctrl", 2'd0, 1'b0, 32'h0,        32'h0};
    vt[1]  = '{"rst_stat", 2'd1, 1'b0, 32'h0,        32'h0};
    vt[2]  = '{"rst_data", 2'd2, 1'b0, 32'h0,        32'h0};
    vt[3]  = '{"rst_dump", 2'd3, 1'b0, 32'h0,        32'h0};
    vt[4]  = '{"wr_dump",  2'd3, 1'b1, 32'h5,        32'h0};
    vt[5]  = '{"rd_dump",  2'd3, 1'b0, 32'h0,        32'h5};
    vt[6]  = '{"wr_dumpw", 2'd3, 1'b1, 32'hFFFFFFFF, 32'h0};
    vt[7]  = '{"dump_msk", 2'd3, 1'b0, 32'h0,        32'h3F};
    vt[8]  = '{"wr_ctrl",  2'd0, 1'b1, 32'h00001F0C, 32'h0};
    vt[9]  = '{"ctrl_rb",  2'd0, 1'b0, 32'h0,        32'h00001F04};
    vt[10] = '{"stat_idle",2'd1, 1'b0, 32'h0,        32'h0};
    vt[11] = '{"wr_data",  2'd2, 1'b1, 32'h5A,       32'h0};
    vt[12] = '{"data_rd",  2'd2, 1'b0, 32'h0,        32'h0};

    reset_n = 1'b0; avs_address = '0; avs_chipselect = 1'b0; avs_write_n = 1'b1;
    avs_writedata = '0; axis4_m_tready = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 13; i++) begin
      if (vt[i].wr) avs_wr(vt[i].a, vt[i].wd);
      else begin
        avs_rd(vt[i].a, r);
        chk(vt[i].nm, r, vt[i].exp);
      end
    end

    // Single write then read of address 5.
    avs_wr(2'd1, 32'h1);
    avs_wr(2'd2, 32'hA5);
    ctrl_go(32'h503, b);
    chk("wr_busy", b, 1);
    avs_rd(2'd1, r);
    chk("wr_done", r[2], 1);
    avs_wr(2'd1, 32'h1);
    ctrl_go(32'h501, b);
    chk("rd_busy", b, 2);
    avs_rd(2'd2, r);
    chk("rd_data", r, 32'hA5);
    avs_rd(2'd1, r);
    chk("rd_done", r[3:0], 4'b0100);

    for (int i = 0; i < DEPTH; i++) mem_write(i, i);

    // Wrapping dump at full rate.
    q.delete(); axis4_m_tready = 1'b1;
    avs_wr(2'd1, 32'h1);
    avs_wr(2'd3, 32'd4);
    ctrl_go(32'h1E05, b);
    chk("dump_rate", b, 8);
    chk_dump(30, 4, 4, 0);
    avs_rd(2'd1, r);
    chk("dump_cnt", r[31:16], 4);
    chk("dump_flags", r[3:0], 4'b0100);

    // Same dump, stalled for 5 cycles on beat 2.
    q.delete(); axis4_m_tready = 1'b0;
    avs_wr(2'd1, 32'h1);
    avs_wr(2'd0, 32'h1E05);
    for (int bt = 0; bt < 4; bt++) begin
      wait_valid();
      if (bt == 2) begin
        repeat (5) begin
          chk("stall_valid", axis4_m_tvalid, 1);
          chk("stall_data", axis4_m_tdata, 0);
          @(negedge clk); #1;
        end
      end
      beat_once();
    end
    wait_idle();
    chk_dump(30, 4, 4, 0);

    // Abort while beat 3 of 8 is stalled.
    q.delete();
    avs_wr(2'd1, 32'h1);
    avs_wr(2'd3, 32'd8);
    avs_wr(2'd0, 32'h0005);
    for (int bt = 0; bt < 3; bt++) begin
      wait_valid();
      beat_once();
    end
    wait_valid();
    chk("ab_last_pre", axis4_m_tlast, 0);
    avs_wr(2'd0, 32'h8);
    #1;
    chk("ab_valid", axis4_m_tvalid, 1);
    chk("ab_last", axis4_m_tlast, 1);
    beat_once();
    wait_idle();
    chk_dump(0, 8, 4, 1);
    avs_rd(2'd1, r);
    chk("ab_flags", r[3:0], 4'b1000);
    chk("ab_cnt", r[31:16], 4);

    // go while busy: rejected, running dump unaffected by register writes.
    q.delete();
    avs_wr(2'd1, 32'h1);
    avs_wr(2'd3, 32'd3);
    avs_wr(2'd0, 32'h0A05);
    wait_valid();
    avs_wr(2'd2, 32'hEE);
    avs_wr(2'd3, 32'd2);
    avs_wr(2'd0, 32'h0303);
    avs_rd(2'd1, r);
    chk("busy_err", r[1:0], 2'b11);
    rdy_rand = 1'b1;
    wait_idle();
    rdy_rand = 1'b0;
    chk_dump(10, 3, 3, 0);
    mem_read(3, d);
    chk("busy_nowrite", d, model[3]);

    // Reserved command.
    q.delete(); axis4_m_tready = 1'b1;
    avs_wr(2'd1, 32'h1);
    ctrl_go(32'h0107, b);
    chk("rsv_busy", b, 0);
    repeat (3) @(negedge clk);
    chk("rsv_nostream", q.size(), 0);
    avs_rd(2'd1, r);
    chk("rsv_err", r[3:0], 4'b0010);

    // Zero-length dump.
    avs_wr(2'd1, 32'h1);
    avs_wr(2'd3, 32'd0);
    ctrl_go(32'h0005, b);
    chk("zlen_busy", b, 0);
    repeat (3) @(negedge clk);
    chk("zlen_nostream", q.size(), 0);
    avs_rd(2'd1, r);
    chk("zlen_err", r[3:0], 4'b0010);
    avs_wr(2'd1, 32'h1);
    avs_rd(2'd1, r);
    chk("err_clear", r[3:0], 4'b0000);

    // Random commands against the model.
    rdy_rand = 1'b1;
    for (int n = 0; n < 60; n++) begin
      op = $urandom_range(0, 2);
      a  = $urandom_range(0, DEPTH - 1);
      case (op)
        0: mem_write(a, $urandom);
        1: begin
          mem_read(a, d);
          chk("rnd_read", d, model[a]);
        end
        default: begin
          len = $urandom_range(1, 40);
          q.delete();
          avs_wr(2'd1, 32'h1);
          avs_wr(2'd3, len);
          ctrl_go(32'h5 | (a << 8), b);
          chk_dump(a, len, len, 0);
          avs_rd(2'd1, r);
          chk("rnd_cnt", r[31:16], len);
          chk("rnd_flags", r[3:0], 4'b0100);
        end
      endcase
    end
    rdy_rand = 1'b0;

    // Asynchronous reset in the middle of a dump.
    axis4_m_tready = 1'b0;
    avs_wr(2'd3, 32'd5);
    avs_wr(2'd0, 32'h0005);
    wait_valid();
    chk("pre_rst_valid", axis4_m_tvalid, 1);
    reset_n = 1'b0;
    avs_address = 2'd1;
    #1;
    chk("rst_valid", axis4_m_tvalid, 0);
    chk("rst_tdata", axis4_m_tdata, 0);
    chk("rst_stat_all", avs_readdata, 0);
    @(negedge clk);
    reset_n = 1'b1;
    axis4_m_tready = 1'b1;
    repeat (4) begin
      @(negedge clk); #1;
      chk("post_rst_valid", axis4_m_tvalid, 0);
    end
    avs_rd(2'd3, r);
    chk("post_rst_dump", r, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
